// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, port ids and default watchdog timeout for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10, HUNG = 2'b11} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: 8-bit busy-cycle counter; ports clk, rst, clr, en in; expire out at TIMEOUT-1
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expire = cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch (i_*) and data (d_*) requesters
// ports: i_* fetch side, d_* data side, m_* downstream request/response, hang sticky watchdog flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  output logic        d_cachehit,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_done,
  input  logic        m_cachehit,
  input  logic        m_err,
  output logic        hang
);
  state_t state, state_n;
  logic last_grant, idle, busy_i, busy_d, busy, bad, d_req, grant_i, grant_d, fin, expire, wd_to;
  assign idle    = state == IDLE;
  assign busy_i  = state == GNT_I;
  assign busy_d  = state == GNT_D;
  assign busy    = busy_i | busy_d;
  assign bad     = idle & d_rd & d_wr;
  assign d_req   = d_rd ^ d_wr;
  // an illegal rd+wr blocks every grant that cycle; ties go to the port not served last
  assign grant_d = idle & ~bad & d_req & (~i_rd | last_grant == PORT_I);
  assign grant_i = idle & ~bad & i_rd & (~d_req | last_grant == PORT_D);
  assign fin     = busy & m_done;
  assign wd_to   = busy & expire & ~m_done;
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(grant_i | grant_d),
    .en(busy & ~m_done),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    state_n = grant_d ? GNT_D : grant_i ? GNT_I : fin ? IDLE : wd_to ? HUNG : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_I;
      m_addr     <= '0;
      m_data_in  <= '0;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_i || grant_d) begin
        last_grant <= grant_d;
        m_addr     <= grant_d ? d_addr : i_addr;
        m_data_in  <= grant_d ? d_data_in : '0;
        m_rd       <= grant_i | d_rd;
        m_wr       <= grant_d & d_wr;
      end else if (fin || wd_to) begin
        m_addr    <= '0;
        m_data_in <= '0;
        m_rd      <= 1'b0;
        m_wr      <= 1'b0;
      end
    end
  end
  assign i_done     = busy_i & (m_done | expire);
  assign i_err      = busy_i & (m_done ? m_err : expire);
  assign i_data_out = busy_i ? m_data_out : '0;
  assign i_stall    = i_rd & ~i_done;
  assign d_done     = (busy_d & (m_done | expire)) | bad;
  assign d_err      = (busy_d & (m_done ? m_err : expire)) | bad;
  assign d_data_out = busy_d ? m_data_out : '0;
  assign d_cachehit = busy_d & m_done & m_cachehit;
  assign d_stall    = (d_rd | d_wr) & ~d_done;
  assign hang       = state == HUNG;
endmodule
